// File: rtl/pipe_pkg.sv
// pipe_pkg
//   Shared types and constants for the RV32I pipeline controller.
//   fwd_sel_t    : E-stage operand source select encoding
//   ctrl_state_t : memory-access sequencer states
//   REG_X0       : architectural zero register index
package pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipe_ctrl_fwd_sel.sv
// fwd_sel
//   Combinational forwarding select for a single E-stage source operand.
//   Ports:
//     rs_e_i        in  5  source register of the instruction in E
//     rd_m_i        in  5  destination register in M
//     reg_write_m_i in  1  M writes the register file
//     rd_w_i        in  5  destination register in W
//     reg_write_w_i in  1  W writes the register file
//     fwd_o         out 2  00 regfile, 01 W result, 10 M alu result
module fwd_sel
    import pipe_pkg::*;
(
    input  logic [4:0] rs_e_i,
    input  logic [4:0] rd_m_i,
    input  logic       reg_write_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       reg_write_w_i,
    output logic [1:0] fwd_o
);

    fwd_sel_t sel;

    // M is the younger producer, so it takes priority over W.
    always_comb begin
        sel = FWD_RF;
        if (reg_write_m_i && (rd_m_i != REG_X0) && (rd_m_i == rs_e_i)) begin
            sel = FWD_M;
        end else if (reg_write_w_i && (rd_w_i != REG_X0) && (rd_w_i == rs_e_i)) begin
            sel = FWD_W;
        end
    end

    assign fwd_o = sel;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
//   Pipeline controller for the 5-stage RV32I core: stall/flush enables for
//   the F/D/E/M/W pipeline registers, E-stage forwarding selects, and a
//   sequencer for multi-cycle data-memory accesses held in M with a timeout
//   watchdog.
//
//   Parameters:
//     MEM_TIMEOUT  max cycles spent in MEM_WAIT before forced release (>=1)
//     CNT_W        width of performance counters
//
//   Optional build macro PIPE_PERF_EN adds performance counter outputs:
//     stall_cycles_o [CNT_W]  cycles with stall_f_o=1
//     flush_cnt_o    [CNT_W]  cycles with flush_d_o=1
//     timeout_cnt_o  [CNT_W]  number of memory timeouts
//
//   Ports:
//     clk_i, rst_ni                   clock, async active-low reset
//     rs1_d_i, rs2_d_i                sources of instruction in D
//     rs1_e_i, rs2_e_i, rd_e_i        sources/destination in E
//     result_src_e0_i                 E instruction is a load
//     pc_src_e_i                      branch/jump taken in E
//     rd_m_i, reg_write_m_i           M destination / write enable
//     dmem_req_m_i, dmem_ack_i        data-memory request in M / completion
//     rd_w_i, reg_write_w_i           W destination / write enable
//     stall_{f,d,e,m}_o               hold PC and pipeline registers
//     flush_d_o, flush_e_o            clear F->D, D->E registers
//     flush_w_o                       bubble into M->W register
//     forward_a_e_o, forward_b_e_o    E operand source selects
//     mem_err_o                       one-cycle pulse on memory timeout
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [4:0] rs1_d_i,
    input  logic [4:0] rs2_d_i,
    input  logic [4:0] rs1_e_i,
    input  logic [4:0] rs2_e_i,
    input  logic [4:0] rd_e_i,
    input  logic       result_src_e0_i,
    input  logic       pc_src_e_i,
    input  logic [4:0] rd_m_i,
    input  logic       reg_write_m_i,
    input  logic       dmem_req_m_i,
    input  logic       dmem_ack_i,
    input  logic [4:0] rd_w_i,
    input  logic       reg_write_w_i,
    output logic       stall_f_o,
    output logic       stall_d_o,
    output logic       stall_e_o,
    output logic       stall_m_o,
    output logic       flush_d_o,
    output logic       flush_e_o,
    output logic       flush_w_o,
    output logic [1:0] forward_a_e_o,
    output logic [1:0] forward_b_e_o,
    output logic       mem_err_o
`ifdef PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] timeout_cnt_o
`endif
);

    localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);

    // Elaboration-time parameter sanity; the blocks are intentionally empty.
    if (MEM_TIMEOUT < 1) begin : g_bad_mem_timeout
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
    end

    ctrl_state_t       state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;

    logic       timeout;
    logic       mem_stall;
    logic       mem_err;
    logic       lw_stall;
    logic [1:0] fwd_a, fwd_b;

    // ------------------------------------------------------------------
    // Forwarding (state-independent)
    // ------------------------------------------------------------------
    fwd_sel u_fwd_a (
        .rs_e_i        (rs1_e_i),
        .rd_m_i        (rd_m_i),
        .reg_write_m_i (reg_write_m_i),
        .rd_w_i        (rd_w_i),
        .reg_write_w_i (reg_write_w_i),
        .fwd_o         (fwd_a)
    );

    fwd_sel u_fwd_b (
        .rs_e_i        (rs2_e_i),
        .rd_m_i        (rd_m_i),
        .reg_write_m_i (reg_write_m_i),
        .rd_w_i        (rd_w_i),
        .reg_write_w_i (reg_write_w_i),
        .fwd_o         (fwd_b)
    );

    // ------------------------------------------------------------------
    // Memory-access sequencer
    // ------------------------------------------------------------------
    assign timeout = (state_q == MEM_WAIT) &&
                     (wcnt_q == WCNT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        mem_stall = 1'b0;
        mem_err   = 1'b0;
        unique case (state_q)
            RUN: begin
                // Ack in the request cycle completes without stalling.
                if (dmem_req_m_i && !dmem_ack_i) begin
                    mem_stall = 1'b1;
                    state_d   = MEM_WAIT;
                    wcnt_d    = '0;
                end
            end
            MEM_WAIT: begin
                if (dmem_ack_i) begin
                    // Ack wins over a coincident timeout.
                    state_d = RUN;
                    wcnt_d  = '0;
                end else if (timeout) begin
                    // Release the stall; the access retires with stale data.
                    mem_err = 1'b1;
                    state_d = RUN;
                    wcnt_d  = '0;
                end else begin
                    mem_stall = 1'b1;
                    wcnt_d    = wcnt_q + WCNT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                wcnt_d  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Hazard resolution and output drive
    // ------------------------------------------------------------------
    assign lw_stall = result_src_e0_i && (rd_e_i != REG_X0) &&
                      ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));

    always_comb begin
        stall_f_o     = 1'b0;
        stall_d_o     = 1'b0;
        stall_e_o     = 1'b0;
        stall_m_o     = 1'b0;
        flush_d_o     = 1'b0;
        flush_e_o     = 1'b0;
        flush_w_o     = 1'b0;
        forward_a_e_o = '0;
        forward_b_e_o = '0;
        mem_err_o     = 1'b0;
        if (rst_ni) begin
            forward_a_e_o = fwd_a;
            forward_b_e_o = fwd_b;
            mem_err_o     = mem_err;
            if (mem_stall) begin
                // Whole front end frozen; a taken branch in E stays held in E
                // and its flushes are issued on the release cycle.
                stall_f_o = 1'b1;
                stall_d_o = 1'b1;
                stall_e_o = 1'b1;
                stall_m_o = 1'b1;
                flush_w_o = 1'b1;
            end else begin
                // With lw_stall and a taken branch together, the datapath's
                // PC redirect overrides the F/D hold.
                stall_f_o = lw_stall;
                stall_d_o = lw_stall;
                flush_d_o = pc_src_e_i;
                flush_e_o = lw_stall | pc_src_e_i;
            end
        end
    end

`ifdef PIPE_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters (wrap at 2^CNT_W)
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] stall_cycles_q, flush_cnt_q, timeout_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cycles_q <= '0;
            flush_cnt_q    <= '0;
            timeout_cnt_q  <= '0;
        end else begin
            if (stall_f_o) begin
                stall_cycles_q <= stall_cycles_q + CNT_W'(1);
            end
            if (flush_d_o) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
            if (mem_err_o) begin
                timeout_cnt_q <= timeout_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_cnt_o    = flush_cnt_q;
    assign timeout_cnt_o  = timeout_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl
//   Scoreboard bench for pipe_ctrl. The stimulus process drives one input
//   vector per cycle, evaluates a reference model built from the pipeline
//   hazard rules and a "cycles waited on memory" count, and queues the
//   expected outputs; a monitor on the falling edge pops and compares.
module tb_pipe_ctrl;

    localparam int unsigned T     = 6;
    localparam int unsigned CNT_W = 16;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
        logic       load, pcsrc;
        logic [4:0] rdm;
        logic       wm, req, ack;
        logic [4:0] rdw;
        logic       ww;
    } stim_t;

    typedef struct packed {
        logic       sf, sd, se, sm, fd, fe, fw;
        logic [1:0] fa, fb;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       load_e, pc_src_e, reg_write_m, dmem_req, dmem_ack, reg_write_w;
    logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_err;
    logic [1:0] fwd_a, fwd_b;
`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] stall_cycles, flush_cnt, timeout_cnt;
`endif

    always #5 clk = ~clk;

    pipe_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CNT_W)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .rs1_d_i         (rs1_d),
        .rs2_d_i         (rs2_d),
        .rs1_e_i         (rs1_e),
        .rs2_e_i         (rs2_e),
        .rd_e_i          (rd_e),
        .result_src_e0_i (load_e),
        .pc_src_e_i      (pc_src_e),
        .rd_m_i          (rd_m),
        .reg_write_m_i   (reg_write_m),
        .dmem_req_m_i    (dmem_req),
        .dmem_ack_i      (dmem_ack),
        .rd_w_i          (rd_w),
        .reg_write_w_i   (reg_write_w),
        .stall_f_o       (stall_f),
        .stall_d_o       (stall_d),
        .stall_e_o       (stall_e),
        .stall_m_o       (stall_m),
        .flush_d_o       (flush_d),
        .flush_e_o       (flush_e),
        .flush_w_o       (flush_w),
        .forward_a_e_o   (fwd_a),
        .forward_b_e_o   (fwd_b),
        .mem_err_o       (mem_err)
`ifdef PIPE_PERF_EN
        ,
        .stall_cycles_o  (stall_cycles),
        .flush_cnt_o     (flush_cnt),
        .timeout_cnt_o   (timeout_cnt)
`endif
    );

    int   tests = 0;
    int   fails = 0;
    exp_t sb_q[$];
    bit   stim_done = 1'b0;

    // Reference model state: is an M-stage access outstanding, and how many
    // cycles has it already been waiting beyond its issue cycle.
    bit waiting = 1'b0;
    int waited  = 0;

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input stim_t s);
        if (s.wm && s.rdm != 0 && s.rdm == rs) return 2'b10;
        if (s.ww && s.rdw != 0 && s.rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic stim_t quiet();
        stim_t s;
        s = '0;
        s.rst = 1'b1;
        return s;
    endfunction

    function automatic stim_t rnd(input bit allow_rst);
        stim_t s;
        s.rst   = allow_rst ? ($urandom_range(0, 199) != 0) : 1'b1;
        s.rs1d  = 5'($urandom_range(0, 7));
        s.rs2d  = 5'($urandom_range(0, 7));
        s.rs1e  = 5'($urandom_range(0, 7));
        s.rs2e  = 5'($urandom_range(0, 7));
        s.rde   = 5'($urandom_range(0, 7));
        s.rdm   = 5'($urandom_range(0, 7));
        s.rdw   = 5'($urandom_range(0, 7));
        s.load  = 1'($urandom_range(0, 1));
        s.pcsrc = ($urandom_range(0, 3) == 0);
        s.wm    = 1'($urandom_range(0, 1));
        s.ww    = 1'($urandom_range(0, 1));
        s.req   = ($urandom_range(0, 2) != 0);
        s.ack   = ($urandom_range(0, 3) == 0);
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        bit   hold, err, lw;
        @(posedge clk);
        #1;
        rst_ni = s.rst;      rs1_d = s.rs1d;   rs2_d = s.rs2d;
        rs1_e = s.rs1e;      rs2_e = s.rs2e;   rd_e = s.rde;
        load_e = s.load;     pc_src_e = s.pcsrc;
        rd_m = s.rdm;        reg_write_m = s.wm;
        dmem_req = s.req;    dmem_ack = s.ack;
        rd_w = s.rdw;        reg_write_w = s.ww;

        e = '0;
        if (!s.rst) begin
            waiting = 1'b0;
            waited  = 0;
        end else begin
            if (!waiting) begin
                hold = s.req && !s.ack;
                err  = 1'b0;
            end else begin
                // Waited T-1 cycles already: this is the last allowed cycle.
                hold = !s.ack && (waited < T - 1);
                err  = !s.ack && (waited == T - 1);
            end
            lw = s.load && s.rde != 0 && (s.rde == s.rs1d || s.rde == s.rs2d);
            e.fa  = ref_fwd(s.rs1e, s);
            e.fb  = ref_fwd(s.rs2e, s);
            e.err = err;
            if (hold) begin
                {e.sf, e.sd, e.se, e.sm, e.fw} = '1;
            end else begin
                e.sf = lw;
                e.sd = lw;
                e.fd = s.pcsrc;
                e.fe = lw || s.pcsrc;
            end
            // Advance the model to the next clock edge.
            if (!waiting) begin
                if (s.req && !s.ack) begin
                    waiting = 1'b1;
                    waited  = 0;
                end
            end else if (s.ack || waited == T - 1) begin
                waiting = 1'b0;
            end else begin
                waited++;
            end
        end
        sb_q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        stim_t s;
        rst_ni = 1'b0;
        {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
        {load_e, pc_src_e, reg_write_m, dmem_req, dmem_ack, reg_write_w} = '0;
        fork
            begin : stimulus
                // Held in reset with busy inputs: everything must be 0.
                for (int i = 0; i < 2; i++) begin
                    s = rnd(1'b0);
                    s.rst = 1'b0;
                    s.wm = 1'b1; s.rdm = 5'd3; s.rs1e = 5'd3; s.req = 1'b1; s.ack = 1'b0;
                    step(s);
                end
                // Forwarding: M priority, x0 never forwarded, W-only match.
                s = quiet(); s.rdm = 5; s.wm = 1; s.rdw = 5; s.ww = 1; s.rs1e = 5; step(s);
                s = quiet(); s.rdm = 0; s.wm = 1; s.rdw = 0; s.ww = 1; s.rs1e = 0; step(s);
                s = quiet(); s.rdm = 3; s.wm = 1; s.rdw = 5; s.ww = 1; s.rs2e = 5; step(s);
                // Load-use hazard and the rd=x0 exemption.
                s = quiet(); s.load = 1; s.rde = 7; s.rs2d = 7; step(s);
                s = quiet(); s.load = 1; s.rde = 0; s.rs1d = 0; step(s);
                // Ack after three stalled cycles, then same-cycle ack.
                s = quiet(); s.req = 1;
                repeat (3) step(s);
                s.ack = 1; step(s);
                step(s);
                step(quiet());
                // Timeout with no ack, then ack on the very last allowed cycle.
                s = quiet(); s.req = 1;
                repeat (T + 1) step(s);
                step(quiet());
                s = quiet(); s.req = 1;
                repeat (T) step(s);
                s.ack = 1; step(s);
                step(quiet());
                // Taken branch held while the memory stall is in force.
                s = quiet(); s.req = 1; step(s);
                s.pcsrc = 1; step(s); step(s);
                s.ack = 1; step(s);
                step(quiet());
                // Reset on the fifth MEM_WAIT cycle, then no late error pulse.
                s = quiet(); s.req = 1;
                repeat (5) step(s);
                s.rst = 0; step(s);
                repeat (T + 2) step(quiet());
                // Randomised traffic with occasional resets.
                for (int i = 0; i < 3000; i++) step(rnd(1'b1));
                stim_done = 1'b1;
            end
            begin : monitor
                exp_t e;
                for (int c = 0; c < 10000; c++) begin
                    @(negedge clk);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        chk("stall_f", {1'b0, stall_f}, {1'b0, e.sf});
                        chk("stall_d", {1'b0, stall_d}, {1'b0, e.sd});
                        chk("stall_e", {1'b0, stall_e}, {1'b0, e.se});
                        chk("stall_m", {1'b0, stall_m}, {1'b0, e.sm});
                        chk("flush_d", {1'b0, flush_d}, {1'b0, e.fd});
                        chk("flush_e", {1'b0, flush_e}, {1'b0, e.fe});
                        chk("flush_w", {1'b0, flush_w}, {1'b0, e.fw});
                        chk("forward_a", fwd_a, e.fa);
                        chk("forward_b", fwd_b, e.fb);
                        chk("mem_err", {1'b0, mem_err}, {1'b0, e.err});
                    end else if (stim_done) begin
                        break;
                    end
                end
                tests++;
                if (!stim_done || sb_q.size() != 0) begin
                    fails++;
                    $display("FAIL drain: pending=%0d expected 0 done=%0d", sb_q.size(), stim_done);
                end
            end
        join_any
        disable fork;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
